// File: rtl/goldschmidt_divider.sv
// Iterative Goldschmidt divider: one shared WxW multiplier alternates between d and n updates.
// Optional DIVIDER_DIV0_DETECT_EN: a zero denominator short-circuits to DONE with a saturated result.
module goldschmidt_divider #(
  parameter int WIDTH = 16,
  parameter int GUARD = 3,
  parameter int ITERS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] IA,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic             div0
);

  localparam int W = WIDTH + GUARD;
  localparam logic [3:0]   ITERS_C     = 4'(ITERS);
  localparam logic [W-1:0] ONE_W       = 1;
  localparam logic [W-1:0] ZERO_W      = '0;
  localparam logic [W-1:0] STICKY_MASK = (ONE_W << (GUARD - 1)) - ONE_W;

  typedef enum logic [1:0] {IDLE, MUL_D, MUL_N, DONE} state_t;

  state_t         state, state_next;
  logic [W-1:0]   n, d, k;
  logic [3:0]     cnt;
  logic [W-1:0]   mul_a;
  logic [2*W-1:0] prod;
  logic [W-1:0]   prod_rne;
  logic           accept;
  logic           last;
  logic           div0_hit;

  // Q2.(2W-2) product back to Q1.(W-1), round-to-nearest-even, saturating.
  function automatic logic [W-1:0] rne_w(input logic [2*W-1:0] p);
    logic [W:0] sum;
    logic       up;
    up  = p[W-2] & ((|p[W-3:0]) | p[W-1]);
    sum = {1'b0, p[2*W-2:W-1]} + {{W{1'b0}}, up};
    if (p[2*W-1] || sum[W]) return '1;
    return sum[W-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] rne_out(input logic [W-1:0] v);
    logic [WIDTH:0] sum;
    logic           up;
    logic           sticky;
    sticky = |(v & STICKY_MASK);
    up     = v[GUARD-1] & (sticky | v[GUARD]);
    sum    = {1'b0, v[W-1:GUARD]} + {{WIDTH{1'b0}}, up};
    return sum[WIDTH] ? '1 : sum[WIDTH-1:0];
  endfunction

  always_comb begin
    mul_a    = (state == MUL_D) ? d : n;
    prod     = {{W{1'b0}}, mul_a} * {{W{1'b0}}, k};
    prod_rne = rne_w(prod);
    accept   = (state == IDLE) && start;
    last     = (cnt + 4'd1) == ITERS_C;
`ifdef DIVIDER_DIV0_DETECT_EN
    div0_hit = accept && (D == '0);
`else
    div0_hit = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = div0_hit ? DONE : MUL_D;
      MUL_D:   state_next = MUL_N;
      MUL_N:   state_next = last ? DONE : MUL_D;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
    valid = (state == DONE);
  end

  // k for the next round is 2 - d, taken from the d written in the preceding MUL_D.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n      <= '0;
      d      <= '0;
      k      <= '0;
      cnt    <= '0;
      result <= '0;
      div0   <= 1'b0;
    end else begin
      if (accept) begin
        n    <= {N,  {GUARD{1'b0}}};
        d    <= {D,  {GUARD{1'b0}}};
        k    <= {IA, {GUARD{1'b0}}};
        cnt  <= '0;
        div0 <= div0_hit;
        if (div0_hit) result <= '1;
      end else if (state == MUL_D) begin
        d <= prod_rne;
      end else if (state == MUL_N) begin
        n   <= prod_rne;
        k   <= ZERO_W - d;
        cnt <= cnt + 4'd1;
        if (last) result <= rne_out(prod_rne);
      end
    end
  end

endmodule
